// File: rtl/reaction_display.sv
// Reaction-time result path: converts a captured tick count to milliseconds
// (restoring division + double-dabble) and multiplexes a 4-digit display.
module reaction_display #(
   parameter int CLK_PER_MS  = 50_000,
   parameter int REFRESH_DIV = 50_000
) (
   input  logic        i_clk_50m,
   input  logic        i_rst,
   input  logic [2:0]  i_state,
   input  logic [27:0] i_ticks,
   output logic [6:0]  o_seg_n,
   output logic [3:0]  o_dig_n,
   output logic [13:0] o_result_ms,
   output logic [13:0] o_best_ms,
   output logic        o_busy,
   output logic        o_done
);

   localparam logic [2:0] GS_IDLE  = 3'b000;
   localparam logic [2:0] GS_LATE  = 3'b011;
   localparam logic [2:0] GS_EARLY = 3'b110;
   localparam logic [2:0] GS_VALID = 3'b100;

   // Remainder never reaches CLK_PER_MS, so RW-1 bits hold it and RW bits hold the trial value.
   localparam int RW  = $clog2(CLK_PER_MS + 1) + 1;
   localparam int RCW = $clog2(REFRESH_DIV + 1);
   localparam logic [RW-1:0]  DIVISOR     = RW'(CLK_PER_MS);
   localparam logic [RCW-1:0] REFRESH_MAX = RCW'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_L     = 7'b1000111;

   typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_BCD, ST_DONE} conv_t;

   conv_t          state_q, state_d;
   logic [2:0]     prev_state_q;
   logic           capture;
   logic [4:0]     cnt_q;
   logic [27:0]    dividend_q, dividend_d;
   logic [RW-2:0]  rem_q, rem_d;
   logic [RW-1:0]  trial;
   logic           q_bit;
   logic [13:0]    quo_q;
   logic [15:0]    bcd_q;
   logic [15:0]    disp_q;
   logic [RCW-1:0] rcnt_q;
   logic [1:0]     idx_q, idx_d;
   logic [3:0]     lead_show;
   logic [6:0]     seg_d;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // One double-dabble step: add 3 to any digit >= 5, then shift in the next binary bit.
   function automatic logic [15:0] dabble(input logic [15:0] b, input logic in_bit);
      logic [15:0] a;
      for (int i = 0; i < 4; i++)
         a[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
      return (a << 1) | {15'd0, in_bit};
   endfunction

   assign capture = (i_state == GS_VALID) && (prev_state_q != GS_VALID);

   always_ff @(posedge i_clk_50m or posedge i_rst) begin
      if (i_rst) begin
         prev_state_q <= GS_IDLE;
         state_q      <= ST_IDLE;
      end else begin
         prev_state_q <= i_state;
         state_q      <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      o_busy  = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: if (capture)          state_d = ST_DIV;
         ST_DIV:  if (cnt_q == 5'd27)   state_d = ST_BCD;
         ST_BCD:  if (cnt_q == 5'd13)   state_d = ST_DONE;
         ST_DONE:                       state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      trial      = {rem_q, dividend_q[27]};
      q_bit      = (trial >= DIVISOR);
      rem_d      = q_bit ? (RW-1)'(trial - DIVISOR) : trial[RW-2:0];
      dividend_d = {dividend_q[26:0], q_bit};
   end

   // Arithmetic working registers carry no reset; the FSM decides when they are meaningful.
   always_ff @(posedge i_clk_50m) begin
      case (state_q)
         ST_IDLE: begin
            if (capture) begin
               dividend_q <= i_ticks;
               rem_q      <= '0;
            end
         end
         ST_DIV: begin
            dividend_q <= dividend_d;
            rem_q      <= rem_d;
            if (cnt_q == 5'd27) begin
               quo_q <= dividend_d[13:0];
               bcd_q <= '0;
            end
         end
         ST_BCD: begin
            bcd_q <= dabble(bcd_q, quo_q[13]);
            // Rotating lets the quotient return to its original value after 14 steps.
            quo_q <= {quo_q[12:0], quo_q[13]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk_50m or posedge i_rst) begin
      if (i_rst) begin
         cnt_q       <= '0;
         o_done      <= 1'b0;
         o_result_ms <= '0;
         o_best_ms   <= 14'h3FFF;
         disp_q      <= '0;
      end else begin
         o_done <= 1'b0;
         case (state_q)
            ST_IDLE: if (capture) cnt_q <= '0;
            ST_DIV:  cnt_q <= (cnt_q == 5'd27) ? 5'd0 : cnt_q + 5'd1;
            ST_BCD:  cnt_q <= cnt_q + 5'd1;
            ST_DONE: begin
               o_done      <= 1'b1;
               o_result_ms <= quo_q;
               disp_q      <= bcd_q;
               if (quo_q < o_best_ms) o_best_ms <= quo_q;
            end
            default: ;
         endcase
      end
   end

   // Display multiplexer: output digit select and segments are both taken from the next index.
   always_comb begin
      idx_d        = (rcnt_q == REFRESH_MAX) ? idx_q + 2'd1 : idx_q;
      lead_show[3] = (disp_q[15:12] != 4'd0);
      lead_show[2] = lead_show[3] | (disp_q[11:8] != 4'd0);
      lead_show[1] = lead_show[2] | (disp_q[7:4] != 4'd0);
      lead_show[0] = 1'b1;
      seg_d        = SEG_BLANK;
      case (i_state)
         GS_IDLE:  seg_d = SEG_DASH;
         GS_EARLY: if (idx_d == 2'd3) seg_d = SEG_E;
         GS_LATE:  if (idx_d == 2'd3) seg_d = SEG_L;
         GS_VALID: if (lead_show[idx_d]) seg_d = dec7(disp_q[{idx_d, 2'b00} +: 4]);
         default:  seg_d = SEG_BLANK;
      endcase
   end

   always_ff @(posedge i_clk_50m or posedge i_rst) begin
      if (i_rst) begin
         rcnt_q  <= '0;
         idx_q   <= 2'd0;
         o_dig_n <= 4'b1110;
         o_seg_n <= SEG_BLANK;
      end else begin
         rcnt_q  <= (rcnt_q == REFRESH_MAX) ? '0 : rcnt_q + 1'b1;
         idx_q   <= idx_d;
         o_dig_n <= ~(4'b0001 << idx_d);
         o_seg_n <= seg_d;
      end
   end

endmodule

// File: tb/tb_reaction_display.sv
// Bench for reaction_display: cycle-level behavioural model plus directed scenarios.
module tb_reaction_display;

   localparam int R   = 4;
   localparam int CPM = 50_000;

   localparam logic [2:0] S_IDLE = 3'b000, S_ARMED = 3'b001, S_LIT = 3'b010;
   localparam logic [2:0] S_LATE = 3'b011, S_EARLY = 3'b110, S_VALID = 3'b100;

   localparam logic [6:0] BL = 7'h7F, DASH = 7'b0111111, SE = 7'b0000110, SL = 7'b1000111;

   logic        i_clk_50m;
   logic        i_rst;
   logic [2:0]  i_state;
   logic [27:0] i_ticks;
   logic [6:0]  o_seg_n;
   logic [3:0]  o_dig_n;
   logic [13:0] o_result_ms;
   logic [13:0] o_best_ms;
   logic        o_busy;
   logic        o_done;

   reaction_display #(.CLK_PER_MS(CPM), .REFRESH_DIV(R)) dut (
      .i_clk_50m  (i_clk_50m),
      .i_rst      (i_rst),
      .i_state    (i_state),
      .i_ticks    (i_ticks),
      .o_seg_n    (o_seg_n),
      .o_dig_n    (o_dig_n),
      .o_result_ms(o_result_ms),
      .o_best_ms  (o_best_ms),
      .o_busy     (o_busy),
      .o_done     (o_done)
   );

   initial i_clk_50m = 1'b0;
   always #10 i_clk_50m = ~i_clk_50m;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] dec_pat(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   function automatic int p10(input int k);
      case (k)
         0: return 1;
         1: return 10;
         2: return 100;
         default: return 1000;
      endcase
   endfunction

   // Expected pattern for display position pos (0 = rightmost) given game state and shown value.
   function automatic logic [6:0] m_seg(input logic [2:0] gs, input int pos, input int val);
      case (gs)
         S_IDLE:  return DASH;
         S_EARLY: return (pos == 3) ? SE : BL;
         S_LATE:  return (pos == 3) ? SL : BL;
         S_VALID: return (pos == 0 || val >= p10(pos)) ? dec_pat((val / p10(pos)) % 10) : BL;
         default: return BL;
      endcase
   endfunction

   // Model: n counts edges since reset release; a conversion finishes 43 edges after its capture.
   int         n, done_at, m_q, m_res, m_best, m_val, pos;
   bit         pending, cap;
   logic [2:0] m_prev;
   logic [3:0] exp_dig;
   logic [6:0] exp_seg;
   logic       exp_busy, exp_done;

   always @(posedge i_clk_50m) begin
      if (i_rst) begin
         n = 0; pending = 0; m_prev = S_IDLE; m_res = 0; m_best = 16383; m_val = 0;
         exp_dig = 4'b1110; exp_seg = BL; exp_busy = 0; exp_done = 0;
      end else begin
         n++;
         pos      = (n / R) % 4;
         exp_dig  = 4'b1111 ^ (4'b0001 << pos);
         exp_seg  = m_seg(i_state, pos, m_val);
         exp_done = 0;
         cap      = (i_state == S_VALID) && (m_prev != S_VALID);
         m_prev   = i_state;
         if (pending && n == done_at) begin
            pending  = 0;
            m_res    = m_q;
            m_val    = m_q;
            if (m_q < m_best) m_best = m_q;
            exp_done = 1;
         end else if (cap && !pending) begin
            pending = 1;
            done_at = n + 43;
            m_q     = int'(i_ticks) / CPM;
         end
         exp_busy = pending;
      end
   end

   always @(negedge i_clk_50m) begin
      if (!i_rst) begin
         chk("dig_n",  32'(o_dig_n),     32'(exp_dig));
         chk("seg_n",  32'(o_seg_n),     32'(exp_seg));
         chk("busy",   32'(o_busy),      32'(exp_busy));
         chk("done",   32'(o_done),      32'(exp_done));
         chk("result", 32'(o_result_ms), 32'(m_res));
         chk("best",   32'(o_best_ms),   32'(m_best));
      end
   end

   task automatic idle_for(input int c);
      i_state = S_IDLE;
      repeat (c) @(negedge i_clk_50m);
   endtask

   task automatic run_conv(input string nm, input logic [27:0] t, input int exp_res, input int exp_best);
      int lat;
      @(negedge i_clk_50m);
      i_ticks = t;
      i_state = S_VALID;
      lat = -1;
      for (int k = 1; k <= 80; k++) begin
         @(negedge i_clk_50m);
         if (o_done) begin
            lat = k - 1;
            break;
         end
      end
      chk({nm, "_latency"}, 32'(lat), 32'd43);
      chk({nm, "_result"}, 32'(o_result_ms), 32'(exp_res));
      chk({nm, "_best"}, 32'(o_best_ms), 32'(exp_best));
   endtask

   task automatic chk_disp(input string nm, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
      for (int i = 0; i < 4 * R; i++) begin
         @(negedge i_clk_50m);
         case (o_dig_n)
            4'b0111: chk(nm, 32'(o_seg_n), 32'(e3));
            4'b1011: chk(nm, 32'(o_seg_n), 32'(e2));
            4'b1101: chk(nm, 32'(o_seg_n), 32'(e1));
            4'b1110: chk(nm, 32'(o_seg_n), 32'(e0));
            default: chk({nm, "_onehot"}, 32'(o_dig_n), 32'hE);
         endcase
      end
   endtask

   logic [3:0] rot [4];
   logic [3:0] last_dig;
   int         found, dones;

   initial begin
      rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;
      i_rst = 1'b1; i_state = S_IDLE; i_ticks = '0;
      repeat (3) @(negedge i_clk_50m);
      chk("rst_seg",    32'(o_seg_n),     32'h7F);
      chk("rst_dig",    32'(o_dig_n),     32'hE);
      chk("rst_result", 32'(o_result_ms), 32'd0);
      chk("rst_best",   32'(o_best_ms),   32'h3FFF);
      chk("rst_busy",   32'(o_busy),      32'd0);
      chk("rst_done",   32'(o_done),      32'd0);
      i_rst = 1'b0;
      idle_for(6);
      chk_disp("idle_disp", DASH, DASH, DASH, DASH);

      run_conv("max", 28'hFFFFFFF, 5368, 5368);
      chk_disp("disp_5368", dec_pat(5), dec_pat(3), dec_pat(6), dec_pat(8));
      idle_for(3);
      run_conv("r300", 28'd15_000_000, 300, 300);
      idle_for(3);
      run_conv("r246", 28'd12_345_678, 246, 246);
      chk_disp("disp_246", BL, dec_pat(2), dec_pat(4), dec_pat(6));
      idle_for(3);
      run_conv("r1a", 28'd50_000, 1, 1);
      idle_for(3);
      run_conv("r1b", 28'd99_999, 1, 1);
      chk_disp("disp_1", BL, BL, BL, dec_pat(1));

      // Digit rotation while showing EARLY
      @(negedge i_clk_50m);
      i_state = S_EARLY;
      found = 0;
      last_dig = o_dig_n;
      for (int k = 0; k < 40; k++) begin
         @(negedge i_clk_50m);
         if (o_dig_n == 4'b1110 && last_dig == 4'b0111) begin
            found = 1;
            break;
         end
         last_dig = o_dig_n;
      end
      chk("early_align", 32'(found), 32'd1);
      for (int j = 1; j < 16; j++) begin
         @(negedge i_clk_50m);
         chk("early_rot", 32'(o_dig_n), 32'(rot[j / 4]));
         chk("early_seg", 32'(o_seg_n), 32'((j / 4 == 3) ? SE : BL));
      end
      i_state = S_LATE;
      chk_disp("late_disp", SL, BL, BL, BL);
      i_state = S_ARMED;
      chk_disp("armed_disp", BL, BL, BL, BL);
      i_state = S_LIT;
      repeat (6) @(negedge i_clk_50m);
      i_state = 3'b101;
      repeat (6) @(negedge i_clk_50m);
      i_state = 3'b111;
      repeat (6) @(negedge i_clk_50m);

      // Re-capture during a busy conversion is ignored
      idle_for(3);
      i_ticks = 28'd20_000_000;
      i_state = S_VALID;
      repeat (5) @(negedge i_clk_50m);
      i_state = S_IDLE;
      repeat (5) @(negedge i_clk_50m);
      i_state = S_VALID;
      dones = 0;
      for (int k = 0; k < 70; k++) begin
         @(negedge i_clk_50m);
         if (o_done) dones++;
      end
      chk("single_done", 32'(dones), 32'd1);
      chk("r400_result", 32'(o_result_ms), 32'd400);
      chk("r400_best",   32'(o_best_ms),   32'd1);

      // Reset in the middle of a conversion
      idle_for(3);
      i_ticks = 28'd100_000;
      i_state = S_VALID;
      repeat (10) @(negedge i_clk_50m);
      #3 i_rst = 1'b1;
      #1;
      chk("arst_busy",   32'(o_busy),      32'd0);
      chk("arst_done",   32'(o_done),      32'd0);
      chk("arst_best",   32'(o_best_ms),   32'h3FFF);
      chk("arst_result", 32'(o_result_ms), 32'd0);
      chk("arst_dig",    32'(o_dig_n),     32'hE);
      chk("arst_seg",    32'(o_seg_n),     32'h7F);
      i_state = S_IDLE;
      repeat (2) @(negedge i_clk_50m);
      i_rst = 1'b0;
      dones = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge i_clk_50m);
         if (o_done) dones++;
      end
      chk("abort_no_done", 32'(dones), 32'd0);
      chk("abort_best", 32'(o_best_ms), 32'h3FFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reaction_display.md
REACTION_DISPLAY -- requirements
Module: reaction_display

Interface
REQ-001 Parameter CLK_PER_MS, 50_000, i_clk_50m cycles per millisecond; this is the divisor for tick-to-ms conversion.
REQ-002 Parameter REFRESH_DIV, 50_000, clock cycles per digit-multiplex step.
REQ-003 i_clk_50m  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_state  in  3  game state code: IDLE=000, ARMED=001, LIT=010, LATE=011, EARLY=110, VALID=100.
REQ-006 i_ticks  in  28  reaction time in clock cycles; stable whenever i_state==VALID.
REQ-007 o_seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 o_dig_n  out  4  digit enables, one-hot active-low, bit 3 = leftmost digit, registered.
REQ-009 o_result_ms  out  14  last converted reaction time in ms, binary.
REQ-010 o_best_ms  out  14  minimum o_result_ms since reset; 14'h3FFF means none yet.
REQ-011 o_busy  out  1  high while a conversion is in progress.
REQ-012 o_done  out  1  one-cycle pulse when a conversion completes.

Function
REQ-013 Block SHALL register i_state each cycle; a capture event is the cycle where i_state==VALID and the registered previous value!=VALID.
REQ-014 On a capture event with o_busy low, block SHALL latch i_ticks and enter DIV on the same edge.
REQ-015 A capture event while o_busy is high SHALL be ignored; the conversion in progress is not disturbed.
REQ-016 Conversion FSM: IDLE -> DIV (28 cycles) -> BCD (14 cycles) -> DONE (1 cycle) -> IDLE; o_busy high in DIV, BCD and DONE.
REQ-017 DIV SHALL be restoring division, one quotient bit per cycle, MSB first; quotient = floor(ticks / CLK_PER_MS).
REQ-018 Quotient SHALL be truncated to 14 bits; for 28-bit ticks and CLK_PER_MS=50_000 the maximum is 5368, so no saturation occurs.
REQ-019 BCD SHALL be sequential double-dabble over the 14-bit quotient, one bit per cycle, producing 4 BCD digits.
REQ-020 In DONE, o_result_ms and the 4 display-digit registers SHALL update and o_done SHALL pulse high.
REQ-021 In DONE, o_best_ms SHALL be loaded with the result if result < o_best_ms; an equal result leaves o_best_ms unchanged.
REQ-022 Latency: o_done SHALL be high exactly 43 cycles after the capture edge.
REQ-023 Refresh counter SHALL count 0..REFRESH_DIV-1; on wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-024 o_dig_n SHALL be low only at bit [index]; o_seg_n SHALL carry that digit's pattern, registered on the same edge as o_dig_n.
REQ-025 Content for IDLE: every digit shows '-' (7'b0111111).
REQ-026 Content for ARMED and LIT: every digit blank (7'h7F).
REQ-027 Content for VALID: result digits, leading zeros blanked, digit 0 always shown; during a conversion the previous result digits are shown.
REQ-028 Content for EARLY: digit 3 shows 'E' (7'b0000110), others blank.
REQ-029 Content for LATE: digit 3 shows 'L' (7'b1000111), others blank.
REQ-030 Content for any undefined state code: every digit blank.
REQ-031 Decimal digit patterns are standard active-low: '0'=7'b1000000 ... '9'=7'b0010000.
REQ-032 Display content SHALL follow i_state with one cycle of latency, independent of o_busy.

Reset
REQ-033 On i_rst assertion, outputs SHALL immediately take: o_seg_n=7'h7F, o_dig_n=4'b1110, o_result_ms=0, o_best_ms=14'h3FFF, o_busy=0, o_done=0.
REQ-034 Reset SHALL also set: FSM=IDLE, refresh counter=0, digit index=0, display digits=0, registered previous state=IDLE.
REQ-035 Reset asserted mid-conversion SHALL abort the conversion; no o_done pulse and no o_best_ms update occur.

Verification
REQ-036 i_ticks=12_345_678, i_state IDLE->VALID -> o_done 43 cycles later, o_result_ms=246, display " 246", o_best_ms=246.
REQ-037 Sequence VALID with ticks=50_000, then VALID with ticks=99_999 -> results 1 then 1; o_best_ms=1; display "   1".
REQ-038 i_ticks=28'hFFFFFFF -> o_result_ms=5368; a following result of 300 -> o_best_ms=300.
REQ-039 i_state=EARLY, REFRESH_DIV=4 -> o_dig_n cycles 1110,1101,1011,0111 every 4 clocks; o_seg_n=0000110 only when o_dig_n=0111.
REQ-040 Capture, then i_rst pulse 10 cycles later -> no o_done; o_best_ms=3FFF; o_busy=0 asynchronously.
REQ-041 i_state VALID->IDLE->VALID within 20 cycles -> second capture ignored; exactly one o_done pulse.
